// File: rtl/virtq_notify_sched.sv
// rtl/virtq_notify_sched.sv - virtqueue notify scheduler: pending bitmap, round-robin grant, DMA fetch handshake
// Optional statistics counters are enabled by defining VIRTQ_SCHED_STATS_EN.
module virtq_notify_sched #(
  parameter int NUM_QUEUES = 4,
  parameter int QIDX_W     = 2,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  drv_ok,
  input  logic                  notify_pulse,
  input  logic [QIDX_W-1:0]     notify_qidx,
  input  logic [NUM_QUEUES-1:0] que_enable,
  input  logic [TIMEOUT_W-1:0]  timeout_limit,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [QIDX_W-1:0]     req_qidx,
  input  logic                  done_valid,
  input  logic                  done_err,
  output logic [NUM_QUEUES-1:0] pending,
  output logic                  busy,
  output logic                  err_pulse,
  output logic [QIDX_W-1:0]     err_qidx,
  output logic [15:0]           svc_count,
  output logic [15:0]           coal_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t                  state;
  logic [QIDX_W-1:0]       rr_ptr;
  logic [TIMEOUT_W-1:0]    wait_cnt;
  logic [TIMEOUT_W-1:0]    cnt_inc;
  logic                    notify_ok;
  logic [NUM_QUEUES-1:0]   set_mask;
  logic [NUM_QUEUES-1:0]   grant_mask;
  logic [NUM_QUEUES-1:0]   eligible;
  logic [2*NUM_QUEUES-1:0] elig_dbl;
  logic                    grant_found;
  logic [QIDX_W:0]         grant_sum;
  logic [QIDX_W-1:0]       grant_idx;
  logic [QIDX_W-1:0]       rr_next;
  logic                    grant_fire;
  logic                    timeout_hit;

  assign notify_ok = notify_pulse && drv_ok && (32'(notify_qidx) < NUM_QUEUES);
  assign set_mask  = notify_ok ? (NUM_QUEUES'(1) << notify_qidx) : '0;
  assign eligible  = pending & que_enable;

  // Rotating the doubled vector by rr_ptr turns the wrap-around search into a lowest-set-bit scan.
  assign elig_dbl = {eligible, eligible} >> rr_ptr;

  always_comb begin
    grant_found = 1'b0;
    grant_sum   = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (!grant_found && elig_dbl[i]) begin
        grant_found = 1'b1;
        grant_sum   = {1'b0, rr_ptr} + (QIDX_W+1)'(i);
      end
    end
    if (grant_sum >= (QIDX_W+1)'(NUM_QUEUES)) begin
      grant_sum = grant_sum - (QIDX_W+1)'(NUM_QUEUES);
    end
    grant_idx = grant_sum[QIDX_W-1:0];
  end

  assign rr_next     = (grant_idx == QIDX_W'(NUM_QUEUES-1)) ? '0 : grant_idx + QIDX_W'(1);
  assign grant_fire  = (state == ST_IDLE) && drv_ok && grant_found;
  assign grant_mask  = grant_fire ? (NUM_QUEUES'(1) << grant_idx) : '0;
  assign cnt_inc     = wait_cnt + TIMEOUT_W'(1);
  assign timeout_hit = (timeout_limit != '0) && (cnt_inc == timeout_limit);

  // A notify landing in its own grant cycle re-sets the bit so the queue is serviced again.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pending <= '0;
      rr_ptr  <= '0;
    end else if (!drv_ok) begin
      pending <= '0;
      rr_ptr  <= '0;
    end else begin
      pending <= (pending & ~grant_mask) | set_mask;
      if (grant_fire) begin
        rr_ptr <= rr_next;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      req_valid <= 1'b0;
      req_qidx  <= '0;
      busy      <= 1'b0;
      err_pulse <= 1'b0;
      err_qidx  <= '0;
      wait_cnt  <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_fire) begin
            state     <= ST_REQ;
            req_valid <= 1'b1;
            req_qidx  <= grant_idx;
            busy      <= 1'b1;
          end
        end
        ST_REQ: begin
          // Device reset withdraws the request without a handshake.
          if (!drv_ok) begin
            state     <= ST_IDLE;
            req_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (req_ready) begin
            state     <= ST_WAIT;
            req_valid <= 1'b0;
            wait_cnt  <= '0;
          end
        end
        ST_WAIT: begin
          if (done_valid) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (done_err) begin
              err_pulse <= 1'b1;
              err_qidx  <= req_qidx;
            end
          end else if (timeout_hit) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            err_pulse <= 1'b1;
            err_qidx  <= req_qidx;
          end else begin
            wait_cnt <= cnt_inc;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef VIRTQ_SCHED_STATS_EN
  logic        drv_ok_q;
  logic [15:0] svc_q;
  logic [15:0] coal_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      drv_ok_q <= 1'b0;
      svc_q    <= '0;
      coal_q   <= '0;
    end else begin
      drv_ok_q <= drv_ok;
      if (drv_ok_q && !drv_ok) begin
        svc_q  <= '0;
        coal_q <= '0;
      end else begin
        if ((state == ST_WAIT) && done_valid && (svc_q != 16'hFFFF)) begin
          svc_q <= svc_q + 16'd1;
        end
        if (((pending & set_mask) != '0) && (coal_q != 16'hFFFF)) begin
          coal_q <= coal_q + 16'd1;
        end
      end
    end
  end

  assign svc_count  = svc_q;
  assign coal_count = coal_q;
`else
  assign svc_count  = '0;
  assign coal_count = '0;
`endif

endmodule

// File: tb/tb_virtq_notify_sched.sv
// tb/tb_virtq_notify_sched.sv - scoreboard bench for virtq_notify_sched (honours VIRTQ_SCHED_STATS_EN)
module tb_virtq_notify_sched;

`ifdef VIRTQ_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        drv_ok = 1'b0;
  logic        notify_pulse = 1'b0;
  logic [1:0]  notify_qidx = '0;
  logic [3:0]  que_enable = '0;
  logic [15:0] timeout_limit = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [1:0]  req_qidx;
  logic        done_valid = 1'b0;
  logic        done_err = 1'b0;
  logic [3:0]  pending;
  logic        busy;
  logic        err_pulse;
  logic [1:0]  err_qidx;
  logic [15:0] svc_count;
  logic [15:0] coal_count;

  int total = 0;
  int bad = 0;
  int exp_svc = 0;
  int exp_coal = 0;
  int exp_req[$];
  int exp_err[$];
  int mon_e;

  virtq_notify_sched #(.NUM_QUEUES(4), .QIDX_W(2), .TIMEOUT_W(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .drv_ok(drv_ok),
    .notify_pulse(notify_pulse), .notify_qidx(notify_qidx),
    .que_enable(que_enable), .timeout_limit(timeout_limit),
    .req_valid(req_valid), .req_ready(req_ready), .req_qidx(req_qidx),
    .done_valid(done_valid), .done_err(done_err),
    .pending(pending), .busy(busy), .err_pulse(err_pulse), .err_qidx(err_qidx),
    .svc_count(svc_count), .coal_count(coal_count)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic notify(input int q);
    notify_pulse = 1'b1;
    notify_qidx  = 2'(q);
    tick();
    notify_pulse = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!req_valid && n < 20) begin
      tick();
      n++;
    end
    check("req_valid_seen", {31'd0, req_valid}, 32'd1);
  endtask

  task automatic serve(input int q, input bit err);
    wait_req();
    exp_req.push_back(q);
    req_ready = 1'b1;
    tick();
    req_ready  = 1'b0;
    done_valid = 1'b1;
    done_err   = err;
    if (err) exp_err.push_back(q);
    tick();
    done_valid = 1'b0;
    done_err   = 1'b0;
    exp_svc++;
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_svc"}, {16'd0, svc_count}, STATS ? 32'(exp_svc) : 32'd0);
    check({tag, "_coal"}, {16'd0, coal_count}, STATS ? 32'(exp_coal) : 32'd0);
  endtask

  // Monitor: a handshake or an error strobe consumes the oldest expected entry.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (req_valid && req_ready) begin
        if (exp_req.size() == 0) begin
          check("req_unexpected", {30'd0, req_qidx}, 32'hFFFF);
        end else begin
          mon_e = exp_req.pop_front();
          check("req_qidx", {30'd0, req_qidx}, 32'(mon_e));
        end
      end
      if (err_pulse) begin
        if (exp_err.size() == 0) begin
          check("err_unexpected", {30'd0, err_qidx}, 32'hFFFF);
        end else begin
          mon_e = exp_err.pop_front();
          check("err_qidx", {30'd0, err_qidx}, 32'(mon_e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    check("rst_req_valid", {31'd0, req_valid}, 32'd0);
    check("rst_req_qidx", {30'd0, req_qidx}, 32'd0);
    check("rst_pending", {28'd0, pending}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {29'd0, err_pulse, err_qidx}, 32'd0);
    check_stats("rst");
    aresetn = 1'b1;
    drv_ok = 1'b1;
    que_enable = 4'hF;
    tick();

    // Single notify: 2-cycle latency to req_valid
    notify(2);
    check("lat_pending", {28'd0, pending}, 32'h4);
    check("lat_req_valid_early", {31'd0, req_valid}, 32'd0);
    tick();
    check("lat_req_valid", {31'd0, req_valid}, 32'd1);
    check("lat_busy", {31'd0, busy}, 32'd1);
    check("lat_pending_clr", {28'd0, pending}, 32'h0);
    serve(2, 1'b0);
    check("single_busy", {31'd0, busy}, 32'd0);
    check("single_pending", {28'd0, pending}, 32'h0);
    check("single_err", {31'd0, err_pulse}, 32'd0);
    check_stats("single");

    // Device reset to bring rr_ptr back to 0, then round-robin order
    drv_ok = 1'b0;
    tick();
    drv_ok = 1'b1;
    exp_svc = 0;
    exp_coal = 0;
    que_enable = 4'h0;
    notify(3);
    notify(0);
    notify(1);
    check("rr_pending", {28'd0, pending}, 32'hB);
    que_enable = 4'hF;
    serve(0, 1'b0);
    serve(1, 1'b0);
    serve(3, 1'b0);
    que_enable = 4'h0;
    notify(3);
    notify(0);
    que_enable = 4'hF;
    serve(0, 1'b0);
    serve(3, 1'b0);

    // Coalesce: two notifies before the grant give one request
    que_enable = 4'h0;
    notify(1);
    notify(1);
    exp_coal++;
    que_enable = 4'hF;
    serve(1, 1'b0);
    tick();
    tick();
    tick();
    check("coal_no_second_req", {31'd0, req_valid}, 32'd0);
    check("coal_pending", {28'd0, pending}, 32'h0);
    check_stats("coal");

    // Re-notify in the grant cycle
    notify(1);
    notify(1);
    exp_coal++;
    check("renotify_pending", {28'd0, pending}, 32'h2);
    check("renotify_req", {31'd0, req_valid}, 32'd1);
    serve(1, 1'b0);
    serve(1, 1'b0);
    check_stats("renotify");

    // Gating: drv_ok=0 notify is dropped; disabled queue waits
    drv_ok = 1'b0;
    notify(2);
    exp_svc = 0;
    exp_coal = 0;
    check("gate_drvok_pending", {28'd0, pending}, 32'h0);
    drv_ok = 1'b1;
    que_enable = 4'b1101;
    notify(1);
    tick();
    tick();
    check("gate_en_pending", {28'd0, pending}, 32'h2);
    check("gate_en_noreq", {31'd0, req_valid}, 32'd0);
    que_enable = 4'hF;
    serve(1, 1'b0);

    // Timeout of 8 cycles after acceptance
    timeout_limit = 16'd8;
    notify(0);
    wait_req();
    exp_req.push_back(0);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    exp_err.push_back(0);
    for (int j = 1; j < 8; j++) begin
      tick();
      check("to_early", {31'd0, err_pulse}, 32'd0);
    end
    tick();
    check("to_pulse", {31'd0, err_pulse}, 32'd1);
    check("to_qidx", {30'd0, err_qidx}, 32'd0);
    check("to_busy", {31'd0, busy}, 32'd0);
    tick();
    check("to_pulse_one", {31'd0, err_pulse}, 32'd0);
    timeout_limit = 16'd0;

    // Completion with error
    notify(3);
    serve(3, 1'b1);
    check("derr_pulse", {31'd0, err_pulse}, 32'd1);
    check("derr_qidx", {30'd0, err_qidx}, 32'd3);
    check("derr_busy", {31'd0, busy}, 32'd0);
    check_stats("derr");

    // Device reset during REQ
    que_enable = 4'b0111;
    notify(3);
    notify(2);
    tick();
    check("drst_req", {31'd0, req_valid}, 32'd1);
    check("drst_req_qidx", {30'd0, req_qidx}, 32'd2);
    check("drst_pend_before", {28'd0, pending}, 32'h8);
    drv_ok = 1'b0;
    tick();
    exp_svc = 0;
    exp_coal = 0;
    check("drst_req_drop", {31'd0, req_valid}, 32'd0);
    check("drst_pending", {28'd0, pending}, 32'h0);
    check("drst_busy", {31'd0, busy}, 32'd0);
    drv_ok = 1'b1;
    que_enable = 4'hF;

    // Device reset during WAIT holds until done_valid
    notify(1);
    wait_req();
    exp_req.push_back(1);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    drv_ok = 1'b0;
    for (int j = 0; j < 5; j++) tick();
    exp_svc = 0;
    exp_coal = 0;
    check("wrst_busy_hold", {31'd0, busy}, 32'd1);
    done_valid = 1'b1;
    tick();
    done_valid = 1'b0;
    exp_svc = 1;
    check("wrst_busy_done", {31'd0, busy}, 32'd0);
    check_stats("wrst");
    drv_ok = 1'b1;

    tick();
    tick();
    check("exp_req_left", 32'(exp_req.size()), 32'd0);
    check("exp_err_left", 32'(exp_err.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
